// File: rtl/mem_bridge.sv
// CPU-to-memory bridge: instruction address translation plus a data-side access FSM
// with lane steering, load extension, wait states and fault detection.
module mem_bridge #(
  parameter logic [31:0] IMEM_BASE   = 32'h0040_0000,
  parameter int unsigned IMEM_DEPTH  = 1024,
  parameter logic [31:0] DMEM_BASE   = 32'h1001_0000,
  parameter int unsigned DMEM_DEPTH  = 2048,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // Instruction side
  input  logic [31:0]                   cpu_pc,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  output logic                          imem_fault,
  // CPU data side
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [1:0]                    cpu_size,
  input  logic                          cpu_signed,
  input  logic [31:0]                   cpu_addr,
  input  logic [31:0]                   cpu_wdata,
  output logic [31:0]                   cpu_rdata,
  output logic                          cpu_stall,
  output logic                          cpu_fault,
  output logic [31:0]                   fault_addr,
  // Data memory side
  output logic                          mem_ena,
  output logic                          mem_we,
  output logic [3:0]                    mem_be,
  output logic [$clog2(DMEM_DEPTH)-1:0] mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic [31:0]                   mem_rdata
);

  localparam int unsigned IAW = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW = $clog2(DMEM_DEPTH);
  // One-past-the-end byte addresses, 33 bits so a segment ending at 4 GiB cannot wrap.
  localparam logic [32:0] ImemEnd  = {1'b0, IMEM_BASE} + (33'(IMEM_DEPTH) << 2);
  localparam logic [32:0] DmemEnd  = {1'b0, DMEM_BASE} + (33'(DMEM_DEPTH) << 2);
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          signed_q, signed_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          fault_q, fault_d;
  logic [31:0]   fault_addr_q, fault_addr_d;
  logic          mem_ena_q, mem_ena_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [DAW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  logic          req_fault;

  // Size 3 is treated as a word everywhere below via the default branches.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return lsb[0];
      default: return |lsb;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'd0:    return 4'b0001 << lsb;
      2'd1:    return lsb[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'd0:    return {4{wd[7:0]}};
      2'd1:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Little-endian lane pick followed by sign or zero extension.
  function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                              input logic        sgn,
                                              input logic [1:0]  lsb,
                                              input logic [31:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    case (lsb)
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      default: b = raw[31:24];
    endcase
    h = lsb[1] ? raw[31:16] : raw[15:0];
    case (size)
      2'd0:    return {{24{sgn & b[7]}}, b};
      2'd1:    return {{16{sgn & h[15]}}, h};
      default: return raw;
    endcase
  endfunction

  // Instruction address translation, independent of the data FSM.
  always_comb begin
    imem_addr  = IAW'((cpu_pc - IMEM_BASE) >> 2);
    imem_fault = (cpu_pc[1:0] != 2'b00) || (cpu_pc < IMEM_BASE) || ({1'b0, cpu_pc} >= ImemEnd);
  end

  // Fault classification of the request presented in IDLE.
  always_comb begin
    req_fault = misaligned(cpu_size, cpu_addr[1:0]) || (cpu_addr < DMEM_BASE) ||
                ({1'b0, cpu_addr} >= DmemEnd);
  end

  // Next-state logic for the access FSM and its registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    size_d       = size_q;
    signed_d     = signed_q;
    wdata_d      = wdata_q;
    fault_addr_d = fault_addr_q;
    rdata_d      = 32'h0;
    fault_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          addr_d   = cpu_addr;
          we_d     = cpu_we;
          size_d   = cpu_size;
          signed_d = cpu_signed;
          wdata_d  = cpu_wdata;
          if (req_fault) begin
            state_d      = StDone;
            fault_d      = 1'b1;
            fault_addr_d = cpu_addr;
          end else begin
            state_d = StBusy;
            cnt_d   = WaitInit;
          end
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          if (!we_q) begin
            rdata_d = load_extend(size_q, signed_q, addr_q[1:0], mem_rdata);
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        // Request is still the same instruction here, so it is not re-accepted.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Memory strobes are registered from the upcoming state so they align with BUSY.
    mem_ena_d   = (state_d == StBusy);
    mem_we_d    = mem_ena_d && we_d && (cnt_d == 4'd0);
    mem_be_d    = mem_ena_d ? lane_be(size_d, addr_d[1:0]) : 4'b0000;
    mem_wdata_d = mem_ena_d ? lane_wdata(size_d, wdata_d) : 32'h0;
    mem_addr_d  = mem_ena_d ? DAW'((addr_d - DMEM_BASE) >> 2) : '0;
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      addr_q       <= 32'h0;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
      mem_ena_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      mem_ena_q    <= mem_ena_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Stall must react to the request in the same cycle; gated by reset so it drops at once.
  always_comb begin
    cpu_stall = rst_n && (((state_q == StIdle) && cpu_req) || (state_q == StBusy));
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_fault  = fault_q;
  assign fault_addr = fault_addr_q;
  assign mem_ena    = mem_ena_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed cases plus randomized accesses checked
// against a byte-addressed reference memory.
module tb_mem_bridge;

  localparam logic [31:0] IBASE  = 32'h0040_0000;
  localparam int unsigned IDEPTH = 1024;
  localparam logic [31:0] DBASE  = 32'h1001_0000;
  localparam int unsigned DDEPTH = 2048;
  localparam int unsigned W      = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] cpu_pc;
  logic [9:0]  imem_addr;
  logic        imem_fault;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_signed;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_fault;
  logic [31:0] fault_addr;
  logic        mem_ena;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_bridge #(
    .IMEM_BASE  (IBASE),
    .IMEM_DEPTH (IDEPTH),
    .DMEM_BASE  (DBASE),
    .DMEM_DEPTH (DDEPTH),
    .WAIT_CYCLES(W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_pc    (cpu_pc),
    .imem_addr (imem_addr),
    .imem_fault(imem_fault),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_size  (cpu_size),
    .cpu_signed(cpu_signed),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .cpu_fault (cpu_fault),
    .fault_addr(fault_addr),
    .mem_ena   (mem_ena),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int we_total = 0;
  logic [31:0] exp_fault_addr = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory device attached to the bridge, seeded on the first clock edge.
  logic [31:0] dev_mem [0:DDEPTH-1];
  logic        seeded = 1'b0;
  assign mem_rdata = dev_mem[mem_addr];

  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < int'(DDEPTH); i++) dev_mem[i] <= init_word(i);
      seeded <= 1'b1;
    end else if (mem_ena && mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (mem_be[k]) dev_mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end
  end

  always @(negedge clk) if (mem_we === 1'b1) we_total++;

  // Reference memory as plain bytes.
  logic [7:0] ref_b [0:4*DDEPTH-1];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  task automatic access(input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd);
    int          n, off, sh, stall_n, ena_n, we_n, we_at;
    bit          exp_fault, done;
    longint      val;
    logic [31:0] exp_rd, exp_wd, be_s, wd_s, ad_s, fa_s;
    logic [3:0]  exp_be;
    logic        fault_s;

    n         = nbytes(sz);
    exp_fault = (addr % n != 0) || (longint'(addr) < longint'(DBASE)) ||
                (longint'(addr) >= longint'(DBASE) + 4 * longint'(DDEPTH));
    off       = 0;
    exp_rd    = 32'h0;
    if (!exp_fault) begin
      off = int'(addr - DBASE);
      val = 0;
      for (int k = 0; k < n; k++) val = val | (longint'(ref_b[off+k]) << (8 * k));
      if (sgn && n < 4 && ((val >> (8 * n - 1)) & 1) == 1) val = val - (longint'(1) << (8 * n));
      exp_rd = we ? 32'h0 : val[31:0];
    end else begin
      exp_fault_addr = addr;
    end
    sh     = int'(addr % 4) - int'(addr % n);
    exp_be = 4'(((1 << n) - 1) << sh);
    exp_wd = (n == 1) ? 32'(wd[7:0]) * 32'h0101_0101 :
             (n == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;

    @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_signed = sgn;
    cpu_addr = addr; cpu_wdata = wd;
    stall_n = 0; ena_n = 0; we_n = 0; we_at = 0; done = 1'b0;
    be_s = 0; wd_s = 0; ad_s = 0; fa_s = 0; fault_s = 1'b0; rd = 32'h0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (mem_ena) begin
        ena_n++;
        be_s = 32'(mem_be); wd_s = mem_wdata; ad_s = 32'(mem_addr);
      end
      if (mem_we) begin
        we_n++;
        we_at = ena_n;
      end
      if (cpu_stall) stall_n++;
      else begin
        done = 1'b1;
        rd = cpu_rdata; fault_s = cpu_fault; fa_s = fault_addr;
      end
    end
    if (!done) check_eq("done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;

    check_eq("stall_cycles", stall_n, exp_fault ? 1 : W + 2);
    check_eq("ena_cycles", ena_n, exp_fault ? 0 : W + 1);
    check_eq("we_pulses", we_n, (!exp_fault && we) ? 1 : 0);
    check_eq("cpu_fault", 32'(fault_s), 32'(exp_fault));
    check_eq("fault_addr", fa_s, exp_fault_addr);
    check_eq("cpu_rdata", rd, exp_rd);
    if (!exp_fault) begin
      check_eq("mem_addr", ad_s, (addr - DBASE) / 4);
      check_eq("mem_be", be_s, 32'(exp_be));
      if (we) begin
        check_eq("we_position", we_at, W + 1);
        check_eq("mem_wdata", wd_s, exp_wd);
        for (int k = 0; k < n; k++) ref_b[off+k] = 8'(wd >> (8 * k));
      end
    end
    @(negedge clk);
    check_eq("fault_pulse_end", 32'(cpu_fault), 32'd0);
  endtask

  task automatic check_imem(input logic [31:0] pc);
    bit exp_f;
    cpu_pc = pc;
    #1;
    exp_f = (pc % 4 != 0) || (pc < IBASE) || (longint'(pc) >= longint'(IBASE) + 4 * IDEPTH);
    check_eq("imem_fault", 32'(imem_fault), 32'(exp_f));
    if (!exp_f) check_eq("imem_addr", 32'(imem_addr), (pc - IBASE) / 4);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int          t0, r;

    for (int i = 0; i < int'(DDEPTH); i++) begin
      for (int k = 0; k < 4; k++) ref_b[4*i+k] = 8'(init_word(i) >> (8 * k));
    end
    rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'd2; cpu_signed = 1'b0;
    cpu_addr = DBASE; cpu_wdata = 32'h0; cpu_pc = IBASE;

    // Reset state, with a request pending to show stall is held low.
    repeat (3) @(negedge clk);
    check_eq("rst_cpu_rdata", cpu_rdata, 32'h0);
    check_eq("rst_cpu_fault", 32'(cpu_fault), 32'd0);
    check_eq("rst_fault_addr", fault_addr, 32'h0);
    check_eq("rst_mem_ena", 32'(mem_ena), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_be", 32'(mem_be), 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    check_eq("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed data accesses.
    access(1'b1, 2'd2, 1'b0, 32'h1001_0004, 32'h1234_5678, rd);
    access(1'b0, 2'd2, 1'b0, 32'h1001_0004, 32'h0, rd);
    check_eq("lw_after_sw", rd, 32'h1234_5678);
    access(1'b1, 2'd0, 1'b0, 32'h1001_0003, 32'h0000_00AB, rd);
    access(1'b0, 2'd0, 1'b1, 32'h1001_0003, 32'h0, rd);
    check_eq("lb", rd, 32'hFFFF_FFAB);
    access(1'b0, 2'd0, 1'b0, 32'h1001_0003, 32'h0, rd);
    check_eq("lbu", rd, 32'h0000_00AB);
    access(1'b1, 2'd2, 1'b0, 32'h1001_0000, 32'h8001_1234, rd);
    access(1'b0, 2'd1, 1'b1, 32'h1001_0002, 32'h0, rd);
    check_eq("lh", rd, 32'hFFFF_8001);
    access(1'b0, 2'd1, 1'b0, 32'h1001_0000, 32'h0, rd);
    check_eq("lhu", rd, 32'h0000_1234);
    access(1'b0, 2'd2, 1'b0, 32'h1001_0002, 32'h0, rd);
    access(1'b1, 2'd2, 1'b0, 32'h1000_FFFC, 32'hCAFE_F00D, rd);
    access(1'b0, 2'd0, 1'b0, DBASE + 32'd8192, 32'h0, rd);
    access(1'b0, 2'd3, 1'b0, DBASE + 32'd8188, 32'h0, rd);

    // Reset in the middle of a store: no write may reach memory.
    t0 = we_total;
    @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'd2; cpu_addr = 32'h1001_0008;
    cpu_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_busy_ena", 32'(mem_ena), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_busy_stall", 32'(cpu_stall), 32'd0);
    check_eq("rst_busy_mem_ena", 32'(mem_ena), 32'd0);
    exp_fault_addr = 32'h0;
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_no_write", we_total - t0, 32'd0);
    access(1'b0, 2'd2, 1'b0, 32'h1001_0008, 32'h0, rd);
    check_eq("rst_old_data", rd, init_word(2));

    // Instruction side.
    check_imem(32'h0040_0008);
    check_eq("imem_addr_2", 32'(imem_addr), 32'd2);
    check_imem(32'h0040_0006);
    check_imem(32'h0040_1000);
    check_eq("imem_end_fault", 32'(imem_fault), 32'd1);
    check_imem(32'h003F_FFFC);
    for (int i = 0; i < 20; i++) check_imem(IBASE - 32'd16 + 32'($urandom_range(0, 4127)));

    // Randomized accesses, with occasional out-of-range addresses.
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0)      a = DBASE - 32'd1 - 32'($urandom_range(0, 7));
      else if (r == 1) a = DBASE + 32'd8188 + 32'($urandom_range(0, 11));
      else             a = DBASE + 32'($urandom_range(0, 63));
      access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
